decode_alloc_credit: RTL and testbench

- Parametrised successor to the decode-stage allocation gate.
- Tracks ROB and store-buffer occupancy as credit counters, with multi-wide allocate, commit and retire per cycle.
- Drives a configurable-depth readyn delay line that gates allocation, with a reserve margin so in-flight grants can never overflow a resource.
- Separates speculative stores from committed stores, so a flush (snoop_hit / bco_valid) discards only speculative state.

---
 rtl/decode_alloc_credit.sv | 100 ++++++++++
 tb/tb_decode_alloc_credit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_alloc_credit.sv
// Decode-stage allocation gate: ROB / store-buffer credit counters with a
// readyn delay line and a reserve margin covering grants still in flight.
module decode_alloc_credit #(
    parameter int unsigned ROB_DEPTH    = 16,
    parameter int unsigned SB_DEPTH     = 8,
    parameter int unsigned ALLOC_WIDTH  = 2,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned RETIRE_WIDTH = 1,
    parameter int unsigned GRANT_DELAY  = 2,
    parameter int unsigned RESERVE      = ALLOC_WIDTH * (GRANT_DELAY + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  snoop_hit,
    input  logic                                  bco_valid,
    input  logic                                  alloc_valid,
    input  logic [$clog2(ALLOC_WIDTH+1)-1:0]      alloc_cnt,
    input  logic [$clog2(ALLOC_WIDTH+1)-1:0]      alloc_store_cnt,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0]     commit_cnt,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0]     commit_store_cnt,
    input  logic [$clog2(RETIRE_WIDTH+1)-1:0]     sb_retire_cnt,
    input  logic                                  i_readyn,
    output logic                                  o_readyn,
    output logic                                  alloc_grant,
    output logic [$clog2(ROB_DEPTH+1)-1:0]        rob_free,
    output logic [$clog2(SB_DEPTH+1)-1:0]         sb_free,
    output logic                                  err_underflow
);

    localparam int unsigned ROBW = $clog2(ROB_DEPTH + 1);
    localparam int unsigned SBW  = $clog2(SB_DEPTH + 1);
    localparam int unsigned XW   = 16;
    localparam logic [XW-1:0] ROB_X = XW'(ROB_DEPTH);
    localparam logic [XW-1:0] SB_X  = XW'(SB_DEPTH);
    localparam logic [XW-1:0] RES_X = XW'(RESERVE);

    logic [ROBW-1:0]        rob_cnt;
    logic [SBW-1:0]         sb_spec_cnt;
    logic [SBW-1:0]         sb_cmt_cnt;
    logic [GRANT_DELAY-1:0] dly;

    logic            flush, s_readyn, fits;
    logic [XW-1:0]   rob_x, sb_used, rob_free_x, sb_free_x;
    logic [XW-1:0]   rob_sum, spec_sum, cmt_sum;
    logic [XW-1:0]   rob_next, spec_next, cmt_next;
    logic            rob_uf, spec_uf, cmt_uf;

    // Free-credit view, gating and net next-state arithmetic
    always_comb begin
        flush      = snoop_hit | bco_valid;
        rob_x      = XW'(rob_cnt);
        sb_used    = XW'(sb_spec_cnt) + XW'(sb_cmt_cnt);
        rob_free_x = (rob_x > ROB_X) ? '0 : ROB_X - rob_x;
        sb_free_x  = (sb_used > SB_X) ? '0 : SB_X - sb_used;
        rob_free   = ROBW'(rob_free_x);
        sb_free    = SBW'(sb_free_x);

        s_readyn    = (rob_free_x < RES_X) | (sb_free_x < RES_X) | i_readyn;
        fits        = (rob_free_x >= XW'(alloc_cnt)) & (sb_free_x >= XW'(alloc_store_cnt));
        alloc_grant = alloc_valid & ~dly[GRANT_DELAY-1] & fits & ~flush & ~reset;

        // Subtract after adding the same-cycle allocation; saturate at zero
        rob_sum   = rob_x + (alloc_grant ? XW'(alloc_cnt) : '0);
        spec_sum  = XW'(sb_spec_cnt) + (alloc_grant ? XW'(alloc_store_cnt) : '0);
        cmt_sum   = XW'(sb_cmt_cnt) + XW'(commit_store_cnt);
        rob_uf    = rob_sum < XW'(commit_cnt);
        spec_uf   = spec_sum < XW'(commit_store_cnt);
        cmt_uf    = cmt_sum < XW'(sb_retire_cnt);
        rob_next  = rob_uf  ? '0 : rob_sum  - XW'(commit_cnt);
        spec_next = spec_uf ? '0 : spec_sum - XW'(commit_store_cnt);
        cmt_next  = cmt_uf  ? '0 : cmt_sum  - XW'(sb_retire_cnt);
    end

    assign o_readyn = s_readyn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rob_cnt       <= '0;
            sb_spec_cnt   <= '0;
            sb_cmt_cnt    <= '0;
            dly           <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (snoop_hit) begin
                dly <= '1;
            end else begin
                dly[0] <= s_readyn;
                for (int i = 1; i < int'(GRANT_DELAY); i++) begin
                    dly[i] <= dly[i-1];
                end
            end
            // Committed stores survive a flush; speculative state does not
            rob_cnt       <= flush ? '0 : ROBW'(rob_next);
            sb_spec_cnt   <= flush ? '0 : SBW'(spec_next);
            sb_cmt_cnt    <= SBW'(cmt_next);
            err_underflow <= err_underflow | rob_uf | spec_uf | cmt_uf;
        end
    end

endmodule

// File: tb/tb_decode_alloc_credit.sv
// Self-checking bench for decode_alloc_credit: directed scenarios plus a
// randomized run compared against a history-based credit model.
module tb_decode_alloc_credit;

    localparam int ROB = 16;
    localparam int SB  = 8;
    localparam int AW  = 2;
    localparam int CW  = 2;
    localparam int RW  = 1;
    localparam int GD  = 2;
    localparam int RES = AW * (GD + 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       snoop_hit = 1'b0, bco_valid = 1'b0, alloc_valid = 1'b0;
    logic [1:0] alloc_cnt = '0, alloc_store_cnt = '0;
    logic [1:0] commit_cnt = '0, commit_store_cnt = '0;
    logic [0:0] sb_retire_cnt = '0;
    logic       i_readyn = 1'b0;
    logic       o_readyn, alloc_grant, err_underflow;
    logic [4:0] rob_free;
    logic [3:0] sb_free;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_alloc_credit dut (
        .clk(clk), .reset(reset), .snoop_hit(snoop_hit), .bco_valid(bco_valid),
        .alloc_valid(alloc_valid), .alloc_cnt(alloc_cnt), .alloc_store_cnt(alloc_store_cnt),
        .commit_cnt(commit_cnt), .commit_store_cnt(commit_store_cnt),
        .sb_retire_cnt(sb_retire_cnt), .i_readyn(i_readyn), .o_readyn(o_readyn),
        .alloc_grant(alloc_grant), .rob_free(rob_free), .sb_free(sb_free),
        .err_underflow(err_underflow)
    );

    // Reference model: occupancy as integers, gating from recent history
    int m_rob, m_spec, m_cmt;
    bit m_err;
    bit rd_hist[$];
    bit sn_hist[$];

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int m_rob_free();
        return (m_rob > ROB) ? 0 : ROB - m_rob;
    endfunction

    function automatic int m_sb_free();
        return (m_spec + m_cmt > SB) ? 0 : SB - m_spec - m_cmt;
    endfunction

    function automatic bit m_sready();
        return (m_rob_free() < RES) || (m_sb_free() < RES) || (i_readyn == 1'b1);
    endfunction

    // Blocked if readyn was high GD cycles ago or a snoop hit within the last GD cycles
    function automatic bit m_blocked();
        for (int k = 0; k < GD; k++)
            if (k < sn_hist.size() && sn_hist[k]) return 1'b1;
        if (rd_hist.size() >= GD && rd_hist[GD-1]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_grant();
        return alloc_valid && !m_blocked() && (m_rob_free() >= int'(alloc_cnt)) &&
               (m_sb_free() >= int'(alloc_store_cnt)) && !snoop_hit && !bco_valid && !reset;
    endfunction

    task automatic model_clear();
        m_rob = 0; m_spec = 0; m_cmt = 0; m_err = 0;
        rd_hist.delete(); sn_hist.delete();
    endtask

    task automatic model_step();
        bit g, s;
        int r, sp, c;
        g  = m_grant();
        s  = m_sready();
        r  = m_rob + (g ? int'(alloc_cnt) : 0) - int'(commit_cnt);
        sp = m_spec + (g ? int'(alloc_store_cnt) : 0) - int'(commit_store_cnt);
        c  = m_cmt + int'(commit_store_cnt) - int'(sb_retire_cnt);
        if (r < 0)  begin r = 0;  m_err = 1; end
        if (sp < 0) begin sp = 0; m_err = 1; end
        if (c < 0)  begin c = 0;  m_err = 1; end
        if (snoop_hit || bco_valid) begin r = 0; sp = 0; end
        m_rob = r; m_spec = sp; m_cmt = c;
        rd_hist.push_front(s);
        sn_hist.push_front(snoop_hit);
        while (rd_hist.size() > GD) void'(rd_hist.pop_back());
        while (sn_hist.size() > GD) void'(sn_hist.pop_back());
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        snoop_hit = 0; bco_valid = 0; alloc_valid = 0; alloc_cnt = 0; alloc_store_cnt = 0;
        commit_cnt = 0; commit_store_cnt = 0; sb_retire_cnt = 0; i_readyn = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        model_clear();
        i_readyn = 1;
        #1;
        checks++; if (o_readyn !== 1'b1) begin errors++; $display("FAIL reset_readyn_hi got %0b want 1", o_readyn); end
        i_readyn = 0;
        #1;
        checks++; if (o_readyn !== 1'b0) begin errors++; $display("FAIL reset_readyn_lo got %0b want 0", o_readyn); end
        @(posedge clk); @(negedge clk);
        reset = 0; #1;
        checks++; if (rob_free !== 5'(ROB)) begin errors++; $display("FAIL reset_rob_free got %0d want %0d", rob_free, ROB); end
        checks++; if (sb_free !== 4'(SB)) begin errors++; $display("FAIL reset_sb_free got %0d want %0d", sb_free, SB); end
        checks++; if (alloc_grant !== 1'b0 || err_underflow !== 1'b0) begin
            errors++; $display("FAIL reset_flags got grant=%0b err=%0b want 0 0", alloc_grant, err_underflow);
        end
    endtask

    task automatic test_fill();
        int grants = 0;
        int rise_free = -1;
        do_reset();
        alloc_valid = 1; alloc_cnt = 2;
        for (int c = 0; c < 14; c++) begin
            #1;
            checks++; if (alloc_grant !== m_grant()) begin errors++; $display("FAIL fill_grant cyc %0d got %0b want %0b", c, alloc_grant, m_grant()); end
            checks++; if (int'(rob_free) !== m_rob_free()) begin errors++; $display("FAIL fill_rob_free cyc %0d got %0d want %0d", c, rob_free, m_rob_free()); end
            if (alloc_grant) grants++;
            if (o_readyn && rise_free < 0) rise_free = int'(rob_free);
            tick();
        end
        checks++; if (grants !== 8) begin errors++; $display("FAIL fill_grant_count got %0d want 8", grants); end
        checks++; if (rise_free !== 4) begin errors++; $display("FAIL fill_readyn_rise got rob_free=%0d want 4", rise_free); end
        checks++; if (rob_free !== 5'd0) begin errors++; $display("FAIL fill_final got %0d want 0", rob_free); end
    endtask

    task automatic test_snoop();
        do_reset();
        alloc_valid = 1; alloc_cnt = 2;
        tick(); tick(); tick();
        #1;
        checks++; if (rob_free !== 5'd10) begin errors++; $display("FAIL snoop_pre got %0d want 10", rob_free); end
        alloc_cnt = 1; snoop_hit = 1; #1;
        checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL snoop_t got %0b want 0", alloc_grant); end
        tick(); snoop_hit = 0; #1;
        checks++; if (rob_free !== 5'd16) begin errors++; $display("FAIL snoop_rob_clear got %0d want 16", rob_free); end
        checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL snoop_t1 got %0b want 0", alloc_grant); end
        tick(); #1;
        checks++; if (alloc_grant !== 1'b0) begin errors++; $display("FAIL snoop_t2 got %0b want 0", alloc_grant); end
        tick(); #1;
        checks++; if (alloc_grant !== 1'b1) begin errors++; $display("FAIL snoop_t3 got %0b want 1", alloc_grant); end
        tick();
    endtask

    task automatic test_bco();
        do_reset();
        alloc_valid = 1; alloc_cnt = 2; alloc_store_cnt = 2; tick();
        alloc_cnt = 1; alloc_store_cnt = 1; tick();
        alloc_valid = 0; alloc_cnt = 0; alloc_store_cnt = 0; #1;
        checks++; if (sb_free !== 4'd5) begin errors++; $display("FAIL bco_alloc got %0d want 5", sb_free); end
        commit_cnt = 2; commit_store_cnt = 2; tick();
        commit_cnt = 0; commit_store_cnt = 0; bco_valid = 1; tick();
        bco_valid = 0; #1;
        checks++; if (sb_free !== 4'd6) begin errors++; $display("FAIL bco_sb_free got %0d want 6", sb_free); end
        checks++; if (rob_free !== 5'd16) begin errors++; $display("FAIL bco_rob_free got %0d want 16", rob_free); end
        sb_retire_cnt = 1; tick(); #1;
        checks++; if (sb_free !== 4'd7) begin errors++; $display("FAIL bco_retire1 got %0d want 7", sb_free); end
        tick(); sb_retire_cnt = 0; #1;
        checks++; if (sb_free !== 4'd8) begin errors++; $display("FAIL bco_retire2 got %0d want 8", sb_free); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL bco_err got %0b want 0", err_underflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        alloc_valid = 1; alloc_cnt = 1; tick();
        alloc_valid = 0; commit_cnt = 2; #1;
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_before got %0b want 0", err_underflow); end
        tick(); commit_cnt = 0; #1;
        checks++; if (err_underflow !== 1'b1 || rob_free !== 5'd16) begin
            errors++; $display("FAIL uf_set got err=%0b rob_free=%0d want 1 16", err_underflow, rob_free);
        end
        alloc_valid = 1; tick(); alloc_valid = 0; commit_cnt = 1; tick(); commit_cnt = 0; tick(); #1;
        checks++; if (err_underflow !== 1'b1 || rob_free !== 5'd16) begin
            errors++; $display("FAIL uf_sticky got err=%0b rob_free=%0d want 1 16", err_underflow, rob_free);
        end
        do_reset();
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_cleared got %0b want 0", err_underflow); end
    endtask

    task automatic test_backpressure();
        bit exp_g[8] = '{1, 1, 0, 0, 0, 0, 1, 1};
        do_reset();
        alloc_valid = 1; alloc_cnt = 1;
        tick(); tick();
        for (int c = 0; c < 8; c++) begin
            i_readyn = (c < 4);
            #1;
            checks++; if (alloc_grant !== exp_g[c]) begin errors++; $display("FAIL bp_grant cyc %0d got %0b want %0b", c, alloc_grant, exp_g[c]); end
            tick();
        end
        alloc_cnt = 0; #1;
        checks++; if (alloc_grant !== 1'b1) begin errors++; $display("FAIL zero_cnt_grant got %0b want 1", alloc_grant); end
        tick(); #1;
        checks++; if (rob_free !== 5'd10) begin errors++; $display("FAIL zero_cnt_free got %0d want 10", rob_free); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_valid = 1; alloc_cnt = 2; alloc_store_cnt = 1; tick(); tick();
        alloc_valid = 0; commit_cnt = 2; commit_store_cnt = 0; sb_retire_cnt = 1; tick();
        idle_inputs(); alloc_valid = 1; alloc_cnt = 1;
        #2; reset = 1; #1;
        checks++; if (rob_free !== 5'd16 || sb_free !== 4'd8 || alloc_grant !== 1'b0 || err_underflow !== 1'b0) begin
            errors++; $display("FAIL async_reset got rob=%0d sb=%0d g=%0b err=%0b want 16 8 0 0", rob_free, sb_free, alloc_grant, err_underflow);
        end
        model_clear();
        @(posedge clk); @(negedge clk);
        reset = 0; idle_inputs(); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int cc;
            alloc_valid      = ($urandom_range(0, 3) != 0);
            alloc_cnt        = 2'($urandom_range(0, AW));
            alloc_store_cnt  = 2'($urandom_range(0, int'(alloc_cnt)));
            cc               = $urandom_range(0, imin(CW, m_rob));
            commit_cnt       = 2'(cc);
            commit_store_cnt = 2'($urandom_range(0, imin(cc, m_spec)));
            sb_retire_cnt    = 1'($urandom_range(0, imin(RW, m_cmt)));
            snoop_hit        = ($urandom_range(0, 24) == 0);
            bco_valid        = ($urandom_range(0, 19) == 0);
            i_readyn         = ($urandom_range(0, 5) == 0);
            #1;
            checks++; if (alloc_grant !== m_grant() || o_readyn !== m_sready()) begin
                errors++; $display("FAIL rand_gate cyc %0d got g=%0b r=%0b want g=%0b r=%0b", c, alloc_grant, o_readyn, m_grant(), m_sready());
            end
            checks++; if (int'(rob_free) !== m_rob_free() || int'(sb_free) !== m_sb_free() || err_underflow !== m_err) begin
                errors++; $display("FAIL rand_state cyc %0d got rob=%0d sb=%0d err=%0b want rob=%0d sb=%0d err=%0b",
                                   c, rob_free, sb_free, err_underflow, m_rob_free(), m_sb_free(), m_err);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_snoop();
        test_bco();
        test_underflow();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
